// File: rtl/packed_data_register.sv
// packed_data_register
//   Byte-oriented data register. Bytes are loaded or shifted into a WIDTH-bit
//   register while a counter tracks how many bytes have been collected since
//   the last load/clear/acknowledge. A consumer acknowledges a full word with
//   Ack. Overflow is a sticky flag for bytes pushed into an unacknowledged
//   full register.
//
//   Ports:
//     Clock    in   1      rising-edge clock
//     Reset    in   1      asynchronous active-low reset
//     I        in   8      byte data in
//     E        in   1      operation enable
//     FunSel   in   3      operation select
//     Ack      in   1      consumer acknowledge of a full word
//     DROut    out  WIDTH  register contents
//     Count    out  CW     bytes collected
//     Full     out  1      Count == NB
//     Overflow out  1      sticky overflow flag
module packed_data_register #(
  parameter int WIDTH = 32,
  localparam int NB = WIDTH / 8,
  localparam int CW = $clog2(NB + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [7:0]       I,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic             Ack,
  output logic [WIDTH-1:0] DROut,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Overflow
);

  localparam logic [CW-1:0] NB_C  = CW'(NB);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [WIDTH-1:0] dr_reg, dr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             ovf_reg, ovf_next;

  logic             full;
  logic             ack_full;
  logic [WIDTH-1:0] dr_rev;

  // Full comes straight from the count register so it never depends on inputs.
  assign full     = (count_reg == NB_C);
  assign ack_full = Ack & full;

  // Byte-lane reversal: lane k takes lane NB-1-k.
  for (genvar gi = 0; gi < NB; gi++) begin : g_rev
    assign dr_rev[8*gi +: 8] = dr_reg[8*(NB-1-gi) +: 8];
  end

  // An acknowledge empties the counter first; the enabled operation then
  // acts on that emptied count, which is why a shift that coincides with
  // an acknowledge lands at 1 and never raises Overflow.
  always_comb begin
    dr_next    = dr_reg;
    count_next = ack_full ? '0 : count_reg;
    ovf_next   = ovf_reg;
    if (E) begin
      case (FunSel)
        3'b000: begin
          dr_next    = {{(WIDTH-8){I[7]}}, I};
          count_next = ONE_C;
        end
        3'b001: begin
          dr_next    = {{(WIDTH-8){1'b0}}, I};
          count_next = ONE_C;
        end
        3'b010, 3'b011: begin
          dr_next = FunSel[0] ? {I, dr_reg[WIDTH-1:8]} : {dr_reg[WIDTH-9:0], I};
          if (ack_full) begin
            count_next = ONE_C;
          end else if (full) begin
            ovf_next = 1'b1;      // count saturates at NB via the default
          end else begin
            count_next = count_reg + ONE_C;
          end
        end
        3'b100: begin
          dr_next    = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end
        3'b101: dr_next = dr_rev;
        3'b110: dr_next = {dr_reg[WIDTH-9:0], dr_reg[WIDTH-1:WIDTH-8]};
        3'b111: dr_next = {dr_reg[7:0], dr_reg[WIDTH-1:8]};
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dr_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      dr_reg    <= dr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign DROut    = dr_reg;
  assign Count    = count_reg;
  assign Full     = full;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_packed_data_register.sv
// Testbench for packed_data_register: a 32-bit instance checked every cycle
// against a behavioural model, plus directed literal checks, and a 64-bit
// instance sharing the same inputs for the wide shift-in case.
module tb_packed_data_register;

  logic        Clock;
  logic        Reset;
  logic [7:0]  I;
  logic        E;
  logic [2:0]  FunSel;
  logic        Ack;

  logic [31:0] DROut;
  logic [2:0]  Count;
  logic        Full;
  logic        Overflow;

  logic [63:0] DROut64;
  logic [3:0]  Count64;
  logic        Full64;
  logic        Overflow64;

  int pass_cnt  = 0;
  int total_cnt = 0;

  packed_data_register #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .E(E), .FunSel(FunSel), .Ack(Ack),
    .DROut(DROut), .Count(Count), .Full(Full), .Overflow(Overflow)
  );

  packed_data_register #(.WIDTH(64)) dut64 (
    .Clock(Clock), .Reset(Reset), .I(I), .E(E), .FunSel(FunSel), .Ack(Ack),
    .DROut(DROut64), .Count(Count64), .Full(Full64), .Overflow(Overflow64)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Behavioural model of the 32-bit instance: an acknowledge of a full
  // word empties the byte count, then the enabled operation is applied.
  logic [31:0] m_dr;
  int          m_cnt;
  bit          m_ovf;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_dr  = 32'h0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (Ack && m_cnt == 4) m_cnt = 0;
      if (E) begin
        case (FunSel)
          3'd0: begin m_dr = 32'($signed(I)); m_cnt = 1; end
          3'd1: begin m_dr = {24'h0, I}; m_cnt = 1; end
          3'd2, 3'd3: begin
            if (FunSel == 3'd2) m_dr = (m_dr << 8) | {24'h0, I};
            else                m_dr = (m_dr >> 8) | ({24'h0, I} << 24);
            if (m_cnt == 4) m_ovf = 1'b1;
            else            m_cnt = m_cnt + 1;
          end
          3'd4: begin m_dr = 32'h0; m_cnt = 0; m_ovf = 1'b0; end
          3'd5: m_dr = {m_dr[7:0], m_dr[15:8], m_dr[23:16], m_dr[31:24]};
          3'd6: m_dr = (m_dr << 8) | (m_dr >> 24);
          default: m_dr = (m_dr >> 8) | (m_dr << 24);
        endcase
      end
    end
  end

  // Per-cycle comparison against the model (outputs are registered, so
  // every falling edge is a meaningful sample point).
  always @(negedge Clock) begin
    total_cnt++;
    if (DROut === m_dr && Count === 3'(m_cnt) && Full === (m_cnt == 4) &&
        Overflow === m_ovf) begin
      pass_cnt++;
    end else begin
      $display("FAIL model t=%0t: got DROut=%h Count=%0d Full=%b Ovf=%b, expected DROut=%h Count=%0d Full=%b Ovf=%b",
               $time, DROut, Count, Full, Overflow, m_dr, m_cnt, (m_cnt == 4), m_ovf);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Called at a falling edge; returns at the next falling edge, after the
  // operation has been applied.
  task automatic op(input bit e, input logic [2:0] fs, input logic [7:0] d, input bit a);
    E = e; FunSel = fs; I = d; Ack = a;
    @(negedge Clock);
    E = 1'b0; Ack = 1'b0;
    $display("op E=%b FunSel=%b I=%h Ack=%b -> DROut=%h Count=%0d Full=%b Ovf=%b",
             e, fs, d, a, DROut, Count, Full, Overflow);
  endtask

  initial begin
    Reset = 1'b1; E = 1'b0; FunSel = 3'd0; I = 8'h0; Ack = 1'b0;
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("reset_dr",    64'(DROut),    64'h0);
    chk("reset_count", 64'(Count),    64'h0);
    chk("reset_full",  64'(Full),     64'h0);
    chk("reset_ovf",   64'(Overflow), 64'h0);
    Reset = 1'b1;
    @(negedge Clock);

    // Sign / zero extension loads
    op(1, 3'b000, 8'h80, 0);
    chk("sext_dr", 64'(DROut), 64'hFFFFFF80);
    chk("sext_count", 64'(Count), 64'd1);
    op(1, 3'b001, 8'h80, 0);
    chk("zext_dr", 64'(DROut), 64'h00000080);
    chk("zext_count", 64'(Count), 64'd1);

    // Shift in at LSB, fill, then overflow
    op(1, 3'b100, 8'h00, 0);
    op(1, 3'b010, 8'h11, 0);
    op(1, 3'b010, 8'h22, 0);
    op(1, 3'b010, 8'h33, 0);
    op(1, 3'b010, 8'h44, 0);
    chk("lsb_fill_dr", 64'(DROut), 64'h11223344);
    chk("lsb_fill_count", 64'(Count), 64'd4);
    chk("lsb_fill_full", 64'(Full), 64'd1);
    op(1, 3'b010, 8'h55, 0);
    chk("ovf_dr", 64'(DROut), 64'h22334455);
    chk("ovf_count", 64'(Count), 64'd4);
    chk("ovf_flag", 64'(Overflow), 64'd1);
    op(1, 3'b000, 8'h01, 0);
    chk("ovf_sticky_on_load", 64'(Overflow), 64'd1);

    // MSB shift, reverse, rotates
    op(1, 3'b100, 8'h00, 0);
    chk("clear_ovf", 64'(Overflow), 64'd0);
    op(1, 3'b011, 8'hAA, 0);
    op(1, 3'b011, 8'hBB, 0);
    op(1, 3'b011, 8'hCC, 0);
    op(1, 3'b011, 8'hDD, 0);
    chk("msb_fill_dr", 64'(DROut), 64'hDDCCBBAA);
    op(1, 3'b101, 8'h00, 0);
    chk("reverse_dr", 64'(DROut), 64'hAABBCCDD);
    chk("reverse_count", 64'(Count), 64'd4);
    op(1, 3'b110, 8'h00, 0);
    chk("rotl_dr", 64'(DROut), 64'hBBCCDDAA);
    op(1, 3'b111, 8'h00, 0);
    chk("rotr_dr", 64'(DROut), 64'hAABBCCDD);

    // Asynchronous reset between edges
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_dr",    64'(DROut),    64'h0);
    chk("async_rst_count", 64'(Count),    64'h0);
    chk("async_rst_full",  64'(Full),     64'h0);
    chk("async_rst_ovf",   64'(Overflow), 64'h0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // Ack coinciding with a shift; Ack while not full; Ack alone while full
    op(1, 3'b010, 8'h11, 0);
    op(1, 3'b010, 8'h22, 0);
    op(1, 3'b010, 8'h33, 0);
    op(1, 3'b010, 8'h44, 0);
    op(1, 3'b010, 8'h99, 1);
    chk("ack_shift_count", 64'(Count), 64'd1);
    chk("ack_shift_full", 64'(Full), 64'd0);
    chk("ack_shift_ovf", 64'(Overflow), 64'd0);
    chk("ack_shift_lowbyte", 64'(DROut[7:0]), 64'h99);
    op(0, 3'b000, 8'h00, 1);
    chk("ack_notfull_dr", 64'(DROut), 64'h22334499);
    chk("ack_notfull_count", 64'(Count), 64'd1);
    op(1, 3'b010, 8'hA1, 0);
    op(1, 3'b010, 8'hA2, 0);
    op(1, 3'b010, 8'hA3, 0);
    op(0, 3'b000, 8'h00, 1);
    chk("ack_full_count", 64'(Count), 64'd0);
    chk("ack_full_dr", 64'(DROut), 64'h99A1A2A3);

    // 64-bit instance: eight LSB shift-ins
    op(1, 3'b100, 8'h00, 0);
    for (int k = 1; k <= 8; k++) op(1, 3'b010, 8'(k), 0);
    chk("w64_dr", DROut64, 64'h0102030405060708);
    chk("w64_count", 64'(Count64), 64'd8);
    chk("w64_full", 64'(Full64), 64'd1);

    // Randomized traffic, shifts weighted up so full/overflow/ack cases occur
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] fs;
      fs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) fs = 3'($urandom_range(2, 3));
      if ($urandom_range(0, 199) == 0) begin
        #2 Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
      end
      op(($urandom_range(0, 9) < 7), fs, 8'($urandom), ($urandom_range(0, 9) < 3));
    end

    @(negedge Clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
